// File: rtl/fp_alu_pkg.sv
// Shared types and constants for the floating-point ALU host bridge.
package fp_alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        WAIT_DONE,
        COLLECT,
        RESP
    } fp_host_state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    // Bit positions on the ALU io_in / io_out control buses
    localparam int ALU_START_BIT = 3;
    localparam int ALU_DONE_BIT  = 4;

    // Operand bytes loaded after start, result bytes returned after done
    localparam int N_LOAD_BYTES   = 8;
    localparam int N_RESULT_BYTES = 4;

endpackage

// File: rtl/fp_byte_shifter.sv
// Byte-wide shift register: parallel load, shifts right one byte per enable,
// inserting byte_in at the top. Used both to serialise operands (read the
// low byte, insert zeros) and to gather result bytes (insert bus byte).
module fp_byte_shifter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_data,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] data
);

    // Load has priority over shift; the register holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= {byte_in, data[W-1:8]};
        end
    end

endmodule

// File: rtl/fp_alu_host_if.sv
// Host bridge for the byte-serial floating-point ALU: takes one operand pair
// over a valid/ready request, runs the start + 8-byte load protocol, gathers
// the 4 result bytes and returns them on a valid/ready response.
// Optional build macro FP_HOST_TIMEOUT_EN adds a WAIT_DONE watchdog that
// returns an error response after TIMEOUT_CYCLES+1 idle cycles.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | req_ready high, waiting for a request
// START     | start strobe on alu_io_in for one cycle, opcode presented
// SEND      | operand bytes A[7:0]..A[31:24], B[7:0]..B[31:24] on alu_in
// WAIT_DONE | waiting for alu_done; first result byte taken with it
// COLLECT   | three more result bytes taken unconditionally
// RESP      | rsp_valid high, result held until rsp_ready
module fp_alu_host_if
    import fp_alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic [7:0]  alu_in,
    output logic [7:0]  alu_io_in,
    input  logic [7:0]  alu_out,
    input  logic        alu_done,
    output logic        busy
);

    localparam logic [2:0] K_LAST_LOAD    = 3'(N_LOAD_BYTES - 1);
    localparam logic [2:0] K_LAST_COLLECT = 3'(N_RESULT_BYTES - 2);

    fp_host_state_t state, state_nxt;
    logic [2:0]     k, k_nxt;
    logic           op_load, op_shift;
    logic           res_load, res_shift;
    logic [7:0]     alu_in_nxt;
    logic           timeout_hit;
    logic [63:0]    op_data;
    logic [55:0]    op_hi_unused;
    logic [31:0]    res_data;
    logic           start_r;
    logic [2:0]     op_r;

    // Only the low byte of the operand shifter is ever presented to the ALU
    assign op_hi_unused = op_data[63:8];

    fp_byte_shifter #(.W(64)) u_op_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (op_load),
        .shift     (op_shift),
        .load_data ({req_b, req_a}),
        .byte_in   (8'h00),
        .data      (op_data)
    );

    fp_byte_shifter #(.W(32)) u_res_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (res_load),
        .shift     (res_shift),
        .load_data (32'h0000_0000),
        .byte_in   (alu_out),
        .data      (res_data)
    );

    // Result shifter is only touched between accept and RESP, so it is stable
    // for the whole response phase and doubles as the response register.
    assign rsp_result = res_data;
    assign alu_io_in  = {4'b0000, start_r, op_r};

`ifdef FP_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_r;

    // alu_done takes priority in the FSM, so expiry only matters without done
    assign timeout_hit = (state == WAIT_DONE) && (to_cnt == '0);
    assign rsp_err     = err_r;

    // Watchdog down-counter, reloaded as WAIT_DONE is entered; the error flag
    // is raised on expiry and dropped when the response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_r  <= 1'b0;
        end else begin
            if (state == SEND && state_nxt == WAIT_DONE) begin
                to_cnt <= TO_W'(TIMEOUT_CYCLES);
            end else if (state == WAIT_DONE && to_cnt != '0) begin
                to_cnt <= to_cnt - 1'b1;
            end
            if (state == WAIT_DONE && !alu_done && timeout_hit) begin
                err_r <= 1'b1;
            end else if (state_nxt == IDLE) begin
                err_r <= 1'b0;
            end
        end
    end
`else
    localparam int TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        op_load    = 1'b0;
        op_shift   = 1'b0;
        res_load   = 1'b0;
        res_shift  = 1'b0;
        alu_in_nxt = 8'h00;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_load   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                op_shift   = 1'b1;
                alu_in_nxt = op_data[7:0];
                k_nxt      = 3'd0;
                state_nxt  = SEND;
            end
            SEND: begin
                op_shift = 1'b1;
                if (k == K_LAST_LOAD) begin
                    k_nxt     = 3'd0;
                    state_nxt = WAIT_DONE;
                end else begin
                    alu_in_nxt = op_data[7:0];
                    k_nxt      = k + 3'd1;
                end
            end
            WAIT_DONE: begin
                if (alu_done) begin
                    res_shift = 1'b1;
                    k_nxt     = 3'd0;
                    state_nxt = COLLECT;
                end else if (timeout_hit) begin
                    res_load  = 1'b1;
                    state_nxt = RESP;
                end
            end
            COLLECT: begin
                // alu_done drops during the last byte, so it is not looked at
                res_shift = 1'b1;
                if (k == K_LAST_COLLECT) begin
                    state_nxt = RESP;
                end else begin
                    k_nxt = k + 3'd1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte counter shared by SEND and COLLECT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 3'd0;
        end else begin
            k <= k_nxt;
        end
    end

    // Registered outputs, derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            alu_in    <= 8'h00;
            start_r   <= 1'b0;
            op_r      <= 3'b000;
        end else begin
            req_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            rsp_valid <= (state_nxt == RESP);
            alu_in    <= alu_in_nxt;
            start_r   <= (state_nxt == START);
            // Opcode stays on the bus through the ALU's execute cycle
            if (op_load) begin
                op_r <= req_op;
            end else if (state_nxt == IDLE) begin
                op_r <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_fp_alu_host_if.sv
// Bench for fp_alu_host_if with a behavioural byte-serial FP ALU attached.
module tb_fp_alu_host_if;
    import fp_alu_pkg::*;

    localparam int T = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [2:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [7:0]  alu_in;
    logic [7:0]  alu_io_in;
    logic [7:0]  alu_out;
    logic        alu_done;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit alu_mute = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;
    exp_t sb[$];

    fp_alu_host_if #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_in     (alu_in),
        .alu_io_in  (alu_io_in),
        .alu_out    (alu_out),
        .alu_done   (alu_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    function automatic real sp_to_real(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:0] == 31'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] bits;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        bits = $realtobits(r);
        e = bits[62:52] - 11'd896;
        return {bits[63], e[7:0], bits[51:29]};
    endfunction

    function automatic logic [31:0] alu_calc(input logic [63:0] ops, input logic [2:0] op);
        real ra, rb;
        ra = sp_to_real(ops[31:0]);
        rb = sp_to_real(ops[63:32]);
        return (op == OP_SUB) ? real_to_sp(ra - rb) : real_to_sp(ra + rb);
    endfunction

    logic [7:0]  alu_io_out;
    int          m_phase, m_cnt;
    logic [63:0] m_ops;
    logic [2:0]  m_op;
    logic [31:0] m_res;

    assign alu_done = alu_io_out[ALU_DONE_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase    <= 0;
            m_cnt      <= 0;
            m_ops      <= '0;
            m_op       <= '0;
            m_res      <= '0;
            alu_out    <= '0;
            alu_io_out <= '0;
        end else begin
            case (m_phase)
                0: if (alu_io_in[ALU_START_BIT]) begin
                    m_op    <= alu_io_in[2:0];
                    m_cnt   <= 0;
                    m_phase <= 1;
                end
                1: begin
                    m_ops <= {alu_in, m_ops[63:8]};
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 7) m_phase <= 2;
                end
                2: begin
                    m_res   <= alu_calc(m_ops, m_op);
                    m_phase <= 3;
                end
                3: if (!alu_mute) begin
                    alu_out                  <= m_res[7:0];
                    alu_io_out[ALU_DONE_BIT] <= 1'b1;
                    m_cnt                    <= 1;
                    m_phase                  <= 4;
                end
                4: begin
                    alu_out <= m_res[8*m_cnt +: 8];
                    m_cnt   <= m_cnt + 1;
                    if (m_cnt == 3) begin
                        alu_io_out[ALU_DONE_BIT] <= 1'b0;
                        m_phase                  <= 5;
                    end
                end
                default: begin
                    alu_out <= '0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [31:0] exp_res, input logic exp_err);
        int w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        chk("req_ready_before_accept", 64'(req_ready), 64'(1));
        req_a = a;
        req_b = b;
        req_op = op;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        sb.push_back('{exp_res, exp_err});
        chk("accept_req_ready_low", 64'(req_ready), 64'(0));
        chk("accept_busy", 64'(busy), 64'(1));
        chk("start_io", 64'(alu_io_in), 64'({4'b0000, 1'b1, op}));
    endtask

    task automatic run_to_rsp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                              input int max_cyc, output int lat);
        logic [63:0] ops;
        bit op_ok, start_ok;
        ops = {b, a};
        op_ok = 1'b1;
        start_ok = 1'b1;
        lat = 0;
        for (int n = 1; n <= max_cyc; n++) begin
            tick();
            if (alu_io_in[2:0] !== op) op_ok = 1'b0;
            if (alu_io_in[3] !== 1'b0) start_ok = 1'b0;
            if (n <= 8) chk($sformatf("alu_in_byte%0d", n - 1), 64'(alu_in), 64'(ops[8*(n-1) +: 8]));
            if (n == 9) chk("alu_in_after_load", 64'(alu_in), 64'(0));
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        chk("rsp_valid_within_budget", 64'(rsp_valid), 64'(1));
        chk("op_stable", 64'(op_ok), 64'(1));
        chk("start_single_cycle", 64'(start_ok), 64'(1));
    endtask

    task automatic pop_check();
        exp_t e;
        e.res = '0;
        e.err = 1'b0;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) e = sb.pop_front();
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
        chk("req_ready_after_rsp", 64'(req_ready), 64'(1));
        chk("busy_after_rsp", 64'(busy), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        chk({tag, "_alu_in"}, 64'(alu_in), 64'(0));
        chk({tag, "_alu_io_in"}, 64'(alu_io_in), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        logic [31:0] held;
        bit stable_ok, ready_ok, nostart_ok, saw_valid;

        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: add 1.0 + 2.0 with rsp_ready already high
        rsp_ready = 1'b1;
        send_req(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, 1'b0);
        run_to_rsp(32'h3F80_0000, 32'h4000_0000, OP_ADD, 60, lat);
        chk("add_latency", 64'(lat), 64'(15));
        pop_check();

        // 2: sub 3.0 - 1.0
        send_req(32'h4040_0000, 32'h3F80_0000, OP_SUB, 32'h4000_0000, 1'b0);
        run_to_rsp(32'h4040_0000, 32'h3F80_0000, OP_SUB, 60, lat);
        chk("sub_latency", 64'(lat), 64'(15));
        pop_check();

        // 3: byte order on the load bus
        send_req(32'h1122_3344, 32'h5566_7788, OP_ADD, 32'h5566_7788, 1'b0);
        run_to_rsp(32'h1122_3344, 32'h5566_7788, OP_ADD, 60, lat);
        chk("proto_latency", 64'(lat), 64'(15));
        pop_check();

        // 3b: unknown opcode passes through unchanged (ALU adds)
        send_req(32'h3F80_0000, 32'h3F80_0000, 3'b110, 32'h4000_0000, 1'b0);
        run_to_rsp(32'h3F80_0000, 32'h3F80_0000, 3'b110, 60, lat);
        pop_check();

        // 4: response backpressure with a second request pending
        send_req(32'h4000_0000, 32'h3F80_0000, OP_ADD, 32'h4040_0000, 1'b0);
        run_to_rsp(32'h4000_0000, 32'h3F80_0000, OP_ADD, 60, lat);
        held = rsp_result;
        req_a = 32'h3F80_0000;
        req_b = 32'h3F80_0000;
        req_op = OP_ADD;
        req_valid = 1'b1;
        stable_ok = 1'b1;
        ready_ok = 1'b1;
        nostart_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_result !== held) stable_ok = 1'b0;
            if (req_ready !== 1'b0) ready_ok = 1'b0;
            if (alu_io_in[3] !== 1'b0) nostart_ok = 1'b0;
        end
        chk("bp_rsp_stable", 64'(stable_ok), 64'(1));
        chk("bp_req_ready_low", 64'(ready_ok), 64'(0 + 1));
        chk("bp_no_new_start", 64'(nostart_ok), 64'(1));
        pop_check();
        send_req(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 32'h4000_0000, 1'b0);
        run_to_rsp(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 60, lat);
        chk("bp_second_latency", 64'(lat), 64'(15));
        pop_check();

        // 5: reset while byte 4 is on the load bus
        send_req(32'h1122_3344, 32'h5566_7788, OP_ADD, 32'h5566_7788, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("send_byte4", 64'(alu_in), 64'(8'h88));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        void'(sb.pop_back());
        tick();
        rst_n = 1'b1;
        tick();
        send_req(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 32'h4000_0000, 1'b0);
        run_to_rsp(32'h3F80_0000, 32'h3F80_0000, OP_ADD, 60, lat);
        chk("post_reset_latency", 64'(lat), 64'(15));
        pop_check();

        // 6: ALU never signals done
        alu_mute = 1'b1;
`ifdef FP_HOST_TIMEOUT_EN
        send_req(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h0000_0000, 1'b1);
        run_to_rsp(32'h3F80_0000, 32'h4000_0000, OP_ADD, 200, lat);
        chk("timeout_latency", 64'(lat), 64'(9 + T + 1));
        pop_check();
`else
        send_req(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h0000_0000, 1'b0);
        saw_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rsp_valid !== 1'b0) saw_valid = 1'b1;
        end
        chk("no_timeout_rsp", 64'(saw_valid), 64'(0));
        chk("no_timeout_busy", 64'(busy), 64'(1));
        void'(sb.pop_back());
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        alu_mute = 1'b0;
        tick();
        chk_reset_outputs("final");
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
